// File: rtl/avpio_pkg.sv
// Shared register offsets and STATUS field positions for the timed Avalon output PIO.
package avpio_pkg;

  localparam int ADDR_W = 3;

  typedef logic [ADDR_W-1:0] avpio_addr_t;

  localparam avpio_addr_t AVPIO_DATA      = 3'd0;
  localparam avpio_addr_t AVPIO_SET       = 3'd1;
  localparam avpio_addr_t AVPIO_CLR       = 3'd2;
  localparam avpio_addr_t AVPIO_PULSE     = 3'd3;
  localparam avpio_addr_t AVPIO_STATUS    = 3'd4;
  localparam avpio_addr_t AVPIO_PULSE_LEN = 3'd5;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_CNT_LSB  = 16;

endpackage

// File: rtl/avpio_pulse_timer.sv
// Down-counter that times a hardware pulse; expire is high on the last high cycle.
module avpio_pulse_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             busy,
  output logic [CNT_W-1:0] cnt,
  output logic             expire
);

  logic             busy_r;
  logic [CNT_W-1:0] cnt_r;

  assign expire = busy_r && (cnt_r == CNT_W'(1));
  assign busy   = busy_r;
  assign cnt    = cnt_r;

  // A load (re)starts the count and overrides a coincident expiry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
    end else if (load) begin
      busy_r <= 1'b1;
      cnt_r  <= len;
    end else if (expire) begin
      busy_r <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
    end else if (busy_r) begin
      busy_r <= 1'b1;
      cnt_r  <= cnt_r - CNT_W'(1);
    end else begin
      busy_r <= busy_r;
      cnt_r  <= cnt_r;
    end
  end

endmodule

// File: rtl/avalon_pio_out_timed.sv
// Avalon-MM output PIO with SET/CLR aliases and an optional self-clearing timed pulse.
// Define AVPIO_PULSE_EN to build the PULSE/STATUS/PULSE_LEN registers and the timer.
module avalon_pio_out_timed
  import avpio_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE   = {WIDTH{1'b0}},
  parameter int               CNT_W         = 16,
  parameter int               PULSE_DEFAULT = 32'd1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [WIDTH-1:0]  out_port
);

  logic             wr_s;
  logic [WIDTH-1:0] wd_s;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] data_next_s;
  logic [WIDTH-1:0] base_s;
  logic             unused_s;

  assign wr_s     = chipselect & ~write_n;
  assign wd_s     = writedata[WIDTH-1:0];
  assign unused_s = ^writedata;
  assign out_port = data_r;

`ifdef AVPIO_PULSE_EN
  logic [WIDTH-1:0]                mask_r;
  logic [WIDTH-1:0]                mask_next_s;
  logic [CNT_W-1:0]                pulse_len_r;
  logic [CNT_W-1:0]                cnt_s;
  logic                            busy_s;
  logic                            expire_s;
  logic                            load_s;
  logic [CNT_W+STATUS_CNT_LSB-1:0] cnt_field_s;
  logic [31:0]                     status_s;

  assign load_s      = wr_s && (address == AVPIO_PULSE) && (pulse_len_r != {CNT_W{1'b0}});
  assign cnt_field_s = {cnt_s, {STATUS_CNT_LSB{1'b0}}};
  // Expiry clears the pulsed bits before any CPU operation in the same cycle.
  assign base_s      = expire_s ? (data_r & ~mask_r) : data_r;

  avpio_pulse_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (load_s),
    .len    (pulse_len_r),
    .busy   (busy_s),
    .cnt    (cnt_s),
    .expire (expire_s)
  );

  // STATUS word: busy flag plus remaining count, clipped at bit 31.
  always_comb begin
    status_s                  = 32'(cnt_field_s);
    status_s[STATUS_BUSY_BIT] = busy_s;
  end

  // Pulse mask: dropped at expiry, new pulse bits OR in afterwards.
  always_comb begin
    mask_next_s = expire_s ? {WIDTH{1'b0}} : mask_r;
    if (load_s) begin
      mask_next_s = mask_next_s | wd_s;
    end else begin
      mask_next_s = mask_next_s;
    end
  end

  // Pulse state and PULSE_LEN register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_r      <= {WIDTH{1'b0}};
      pulse_len_r <= CNT_W'(PULSE_DEFAULT);
    end else begin
      mask_r <= mask_next_s;
      if (wr_s && (address == AVPIO_PULSE_LEN)) begin
        pulse_len_r <= writedata[CNT_W-1:0];
      end else begin
        pulse_len_r <= pulse_len_r;
      end
    end
  end
`else
  assign base_s = data_r;
`endif

  // CPU operation applied on top of the (possibly expiry-cleared) data.
  always_comb begin
    data_next_s = base_s;
    if (wr_s) begin
      case (address)
        AVPIO_DATA: data_next_s = wd_s;
        AVPIO_SET:  data_next_s = base_s | wd_s;
        AVPIO_CLR:  data_next_s = base_s & ~wd_s;
`ifdef AVPIO_PULSE_EN
        AVPIO_PULSE: begin
          if (pulse_len_r != {CNT_W{1'b0}}) begin
            data_next_s = base_s | wd_s;
          end else begin
            data_next_s = base_s;
          end
        end
`endif
        default: data_next_s = base_s;
      endcase
    end else begin
      data_next_s = base_s;
    end
  end

  // Output data register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_r <= RESET_VALUE;
    end else begin
      data_r <= data_next_s;
    end
  end

  // Zero-latency read mux.
  always_comb begin
    readdata = 32'd0;
    case (address)
      AVPIO_DATA: readdata = 32'(data_r);
`ifdef AVPIO_PULSE_EN
      AVPIO_STATUS:    readdata = status_s;
      AVPIO_PULSE_LEN: readdata = 32'(pulse_len_r);
`endif
      default: readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_avalon_pio_out_timed.sv
// Self-checking bench for avalon_pio_out_timed against a time-stamp based reference model.
module tb_avalon_pio_out_timed;

  localparam int         WIDTH = 8;
  localparam logic [7:0] RV    = 8'hA5;
  localparam int         CNT_W = 16;
  localparam int         PD    = 1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  always #5 clk = ~clk;

  avalon_pio_out_timed #(
    .WIDTH         (WIDTH),
    .RESET_VALUE   (RV),
    .CNT_W         (CNT_W),
    .PULSE_DEFAULT (PD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: pulsed bits drop at the clock edge numbered m_end.
  logic [7:0] m_data;
  logic [7:0] m_mask;
  bit         m_active;
  longint     m_end;
  longint     edge_cnt = 0;
  int         m_plen;

  task automatic model_reset();
    m_data   = RV;
    m_mask   = 8'h00;
    m_active = 1'b0;
    m_plen   = PD;
  endtask

  function automatic logic [31:0] exp_read(input logic [2:0] a);
    longint rem;
    exp_read = 32'd0;
    case (a)
      3'd0: exp_read = {24'd0, m_data};
`ifdef AVPIO_PULSE_EN
      3'd4: begin
        rem      = m_active ? (m_end - edge_cnt) : 64'd0;
        exp_read = (32'(rem) << 16) | {31'd0, m_active};
      end
      3'd5: exp_read = 32'(m_plen);
`endif
      default: exp_read = 32'd0;
    endcase
  endfunction

  task automatic drive(input bit cs, input bit wr, input logic [2:0] a, input logic [31:0] wd);
    logic [7:0] w8;
    w8         = wd[7:0];
    chipselect = cs;
    write_n    = ~wr;
    address    = a;
    writedata  = wd;
    @(posedge clk);
    edge_cnt++;
    if (m_active && edge_cnt == m_end) begin
      m_data   = m_data & ~m_mask;
      m_mask   = 8'h00;
      m_active = 1'b0;
    end
    if (cs && wr) begin
      case (a)
        3'd0: m_data = w8;
        3'd1: m_data = m_data | w8;
        3'd2: m_data = m_data & ~w8;
`ifdef AVPIO_PULSE_EN
        3'd3: if (m_plen != 0) begin
          m_data   = m_data | w8;
          m_mask   = m_mask | w8;
          m_end    = edge_cnt + longint'(m_plen);
          m_active = 1'b1;
        end
        3'd5: m_plen = int'(wd[15:0]);
`endif
        default: ;
      endcase
    end
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    @(negedge clk);
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = 32'd0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (out_port !== 8'hA5) begin n_fail++; $display("FAIL reset_out_port got %h want %h", out_port, 8'hA5); end
    read_reg(3'd0, rd);
    n_checks++;
    if (rd !== 32'h0000_00A5) begin n_fail++; $display("FAIL reset_data got %h want %h", rd, 32'hA5); end
    read_reg(3'd4, rd);
    n_checks++;
    if (rd !== 32'd0) begin n_fail++; $display("FAIL reset_status got %h want 0", rd); end
    read_reg(3'd5, rd);
    n_checks++;
`ifdef AVPIO_PULSE_EN
    if (rd !== 32'd1000) begin n_fail++; $display("FAIL reset_pulse_len got %0d want 1000", rd); end
`else
    if (rd !== 32'd0) begin n_fail++; $display("FAIL reset_off5 got %h want 0", rd); end
`endif
  endtask

  task automatic test_data_set_clr();
    logic [2:0]  addrs [3] = '{3'd0, 3'd1, 3'd2};
    logic [7:0]  vals  [3] = '{8'h0F, 8'h30, 8'h03};
    logic [7:0]  want  [3] = '{8'h0F, 8'h3F, 8'h3C};
    logic [31:0] rd;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, addrs[i], ($urandom() & 32'hFFFF_FF00) | {24'd0, vals[i]});
      n_checks++;
      if (out_port !== want[i]) begin n_fail++; $display("FAIL dsc_out_port[%0d] got %h want %h", i, out_port, want[i]); end
      read_reg(3'd0, rd);
      n_checks++;
      if (rd !== {24'd0, want[i]}) begin n_fail++; $display("FAIL dsc_readback[%0d] got %h want %h", i, rd, want[i]); end
    end
  endtask

`ifdef AVPIO_PULSE_EN
  task automatic test_pulse_basic();
    int          cnts [6] = '{4, 3, 2, 1, 0, 0};
    logic [31:0] rd;
    logic [31:0] want;
    drive(1'b1, 1'b1, 3'd5, 32'd4);
    drive(1'b1, 1'b1, 3'd3, ($urandom() & 32'hFFFF_FF00) | 32'h80);
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (out_port[7] !== (k < 4)) begin n_fail++; $display("FAIL pulse_bit7[%0d] got %b want %b", k, out_port[7], (k < 4)); end
      n_checks++;
      if (out_port !== m_data) begin n_fail++; $display("FAIL pulse_model[%0d] got %h want %h", k, out_port, m_data); end
      read_reg(3'd4, rd);
      want = (32'(cnts[k]) << 16) | ((k < 4) ? 32'd1 : 32'd0);
      n_checks++;
      if (rd !== want) begin n_fail++; $display("FAIL pulse_status[%0d] got %h want %h", k, rd, want); end
      drive(1'b0, 1'b0, 3'd0, 32'd0);
    end
  endtask

  task automatic test_retrigger();
    drive(1'b1, 1'b1, 3'd5, 32'd10);
    drive(1'b1, 1'b1, 3'd0, 32'd0);
    drive(1'b1, 1'b1, 3'd3, 32'h01);
    repeat (4) drive(1'b0, 1'b0, 3'd0, 32'd0);
    drive(1'b1, 1'b1, 3'd3, 32'h02);
    for (int k = 0; k <= 10; k++) begin
      n_checks++;
      if (out_port[1:0] !== ((k < 10) ? 2'b11 : 2'b00)) begin
        n_fail++; $display("FAIL retrig_bits[%0d] got %b", k, out_port[1:0]);
      end
      n_checks++;
      if (out_port !== m_data) begin n_fail++; $display("FAIL retrig_model[%0d] got %h want %h", k, out_port, m_data); end
      drive(1'b0, 1'b0, 3'd0, 32'd0);
    end
  endtask

  task automatic test_expiry_collision();
    logic [31:0] rd;
    drive(1'b1, 1'b1, 3'd5, 32'd3);
    drive(1'b1, 1'b1, 3'd0, 32'd0);
    drive(1'b1, 1'b1, 3'd3, 32'h01);
    repeat (2) drive(1'b0, 1'b0, 3'd0, 32'd0);
    drive(1'b1, 1'b1, 3'd1, 32'h01);
    n_checks++;
    if (out_port !== 8'h01) begin n_fail++; $display("FAIL expiry_set got %h want 01", out_port); end
    read_reg(3'd4, rd);
    n_checks++;
    if (rd !== 32'd0) begin n_fail++; $display("FAIL expiry_set_status got %h want 0", rd); end
    drive(1'b1, 1'b1, 3'd3, 32'h01);
    repeat (2) drive(1'b0, 1'b0, 3'd0, 32'd0);
    drive(1'b1, 1'b1, 3'd3, 32'h02);
    n_checks++;
    if (out_port !== 8'h02) begin n_fail++; $display("FAIL expiry_pulse got %h want 02", out_port); end
    read_reg(3'd4, rd);
    n_checks++;
    if (rd !== 32'h0003_0001) begin n_fail++; $display("FAIL expiry_pulse_status got %h want 00030001", rd); end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 3'd0, 32'd0);
      n_checks++;
      if (out_port !== m_data) begin n_fail++; $display("FAIL expiry_tail[%0d] got %h want %h", k, out_port, m_data); end
    end
  endtask

  task automatic test_len_zero();
    logic [31:0] rd;
    drive(1'b1, 1'b1, 3'd5, 32'hABCD_0000);
    drive(1'b1, 1'b1, 3'd0, 32'h10);
    drive(1'b1, 1'b1, 3'd3, 32'hFF);
    n_checks++;
    if (out_port !== 8'h10) begin n_fail++; $display("FAIL len0_out got %h want 10", out_port); end
    read_reg(3'd4, rd);
    n_checks++;
    if (rd !== 32'd0) begin n_fail++; $display("FAIL len0_status got %h want 0", rd); end
    read_reg(3'd5, rd);
    n_checks++;
    if (rd !== 32'd0) begin n_fail++; $display("FAIL len0_pulse_len got %h want 0", rd); end
  endtask
`endif

  task automatic test_unused_offsets();
    logic [2:0]  wo [6] = '{3'd6, 3'd7, 3'd3, 3'd4, 3'd5, 3'd0};
    logic [2:0]  ro [4] = '{3'd1, 3'd2, 3'd6, 3'd7};
    logic [31:0] rd;
    drive(1'b1, 1'b1, 3'd0, 32'h5A);
    drive(1'b0, 1'b1, 3'd0, 32'hFF);
    n_checks++;
    if (out_port !== 8'h5A) begin n_fail++; $display("FAIL nocs_write got %h want 5a", out_port); end
`ifdef AVPIO_PULSE_EN
    for (int i = 0; i < 2; i++) begin
`else
    for (int i = 0; i < 5; i++) begin
`endif
      drive(1'b1, 1'b1, wo[i], 32'hFFFF_FF00 | 32'($urandom_range(0, 255)));
      n_checks++;
      if (out_port !== 8'h5A) begin n_fail++; $display("FAIL ignored_wr[%0d] got %h want 5a", wo[i], out_port); end
    end
    for (int i = 0; i < 4; i++) begin
      read_reg(ro[i], rd);
      n_checks++;
      if (rd !== 32'd0) begin n_fail++; $display("FAIL zero_read[%0d] got %h want 0", ro[i], rd); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    for (int k = 0; k < 400; k++) begin
      a  = 3'($urandom_range(0, 7));
      wd = $urandom();
      if (a == 3'd5) wd = (wd & 32'hFFFF_0000) | 32'($urandom_range(0, 6));
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, a, wd);
      n_checks++;
      if (out_port !== m_data) begin n_fail++; $display("FAIL rand_out[%0d] got %h want %h", k, out_port, m_data); end
      read_reg(3'd4, rd);
      n_checks++;
      if (rd !== exp_read(3'd4)) begin n_fail++; $display("FAIL rand_status[%0d] got %h want %h", k, rd, exp_read(3'd4)); end
      read_reg(3'd5, rd);
      n_checks++;
      if (rd !== exp_read(3'd5)) begin n_fail++; $display("FAIL rand_len[%0d] got %h want %h", k, rd, exp_read(3'd5)); end
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic [31:0] rd;
    drive(1'b1, 1'b1, 3'd0, 32'h00);
`ifdef AVPIO_PULSE_EN
    drive(1'b1, 1'b1, 3'd5, 32'd8);
    drive(1'b1, 1'b1, 3'd3, 32'h40);
`endif
    repeat (3) drive(1'b0, 1'b0, 3'd0, 32'd0);
    reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (out_port !== 8'hA5) begin n_fail++; $display("FAIL midreset_out got %h want a5", out_port); end
    read_reg(3'd4, rd);
    n_checks++;
    if (rd !== 32'd0) begin n_fail++; $display("FAIL midreset_status got %h want 0", rd); end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, 3'd0, 32'd0);
      n_checks++;
      if (out_port !== 8'hA5) begin n_fail++; $display("FAIL postreset_out[%0d] got %h want a5", k, out_port); end
    end
    read_reg(3'd5, rd);
    n_checks++;
    if (rd !== exp_read(3'd5)) begin n_fail++; $display("FAIL postreset_len got %h want %h", rd, exp_read(3'd5)); end
  endtask

  initial begin
    test_reset();
    test_data_set_clr();
`ifdef AVPIO_PULSE_EN
    test_pulse_basic();
    test_retrigger();
    test_expiry_collision();
    test_len_zero();
`endif
    test_unused_offsets();
    test_random();
    test_reset_mid_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
